// File: rtl/ft_recovery_ctrl.sv
// Fault-tolerance recovery sequencer for an N-core lockstep cluster: reset/halt faulty cores,
// replay saved PC and GPRs, resume. Define FT_HALT_TIMEOUT_EN to add the halt-acknowledge watchdog.
module ft_recovery_ctrl #(
  parameter int ADDR_WIDTH     = 5,
  parameter int NUM_CORES      = 2,
  parameter int MAX_RETRIES    = 3,
  parameter int CLEAN_CYCLES   = 256,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  error_i,
  input  logic [NUM_CORES-1:0]  faulty_i,
  input  logic [NUM_CORES-1:0]  halted_i,
  output logic [NUM_CORES-1:0]  reset_no,
  output logic [NUM_CORES-1:0]  halt_o,
  output logic [NUM_CORES-1:0]  resume_o,
  output logic                  shift_o,
  output logic                  we_spc_o,
  output logic                  we_sgpr_o,
  output logic [ADDR_WIDTH-1:0] replay_addr_o,
  output logic                  busy_o,
  output logic                  fatal_o,
  output logic [15:0]           recov_count_o
);

  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam int CW = $clog2(CLEAN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RESET, S_HALT, S_HALT_WAIT, S_WORK_SPC, S_WORK_SGPR, S_DONE, S_FATAL
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [NUM_CORES-1:0]  r_mask, w_mask_nxt;
  logic [RW-1:0]         r_retries, w_retries_nxt;
  logic [CW-1:0]         r_clean, w_clean_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [15:0]           r_recov, w_recov_nxt;
  logic [NUM_CORES-1:0]  r_reset_n, r_halt, r_resume, w_reset_n, w_halt, w_resume;
  logic                  r_shift, r_we_spc, r_we_sgpr, r_busy, r_fatal;
  logic                  w_shift, w_we_spc, w_we_sgpr, w_busy, w_fatal;
  logic                  w_ack;

`ifdef FT_HALT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_to, w_to_nxt;
`endif

  assign w_ack = ((halted_i & r_mask) == r_mask);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    w_state_nxt   = r_state;
    w_mask_nxt    = r_mask;
    w_retries_nxt = r_retries;
    w_clean_nxt   = r_clean;
    w_addr_nxt    = '0;
    w_recov_nxt   = r_recov;
`ifdef FT_HALT_TIMEOUT_EN
    w_to_nxt      = r_to;
`endif

    case (r_state)
      S_IDLE: begin
        if (error_i) begin
          w_clean_nxt = '0;
          if (r_retries < RW'(MAX_RETRIES)) begin
            w_state_nxt   = S_RESET;
            w_mask_nxt    = (faulty_i == '0) ? '1 : faulty_i;
            w_retries_nxt = r_retries + RW'(1);
          end else begin
            w_state_nxt = S_FATAL;
          end
        end else if (r_clean == CW'(CLEAN_CYCLES - 1)) begin
          w_clean_nxt   = '0;
          w_retries_nxt = '0;
        end else begin
          w_clean_nxt = r_clean + CW'(1);
        end
      end
      S_RESET: w_state_nxt = S_HALT;
      S_HALT: begin
        w_state_nxt = S_HALT_WAIT;
`ifdef FT_HALT_TIMEOUT_EN
        w_to_nxt    = '0;
`endif
      end
      S_HALT_WAIT: begin
        if (w_ack) begin
          w_state_nxt = S_WORK_SPC;
        end
`ifdef FT_HALT_TIMEOUT_EN
        else if (r_to == TW'(TIMEOUT_CYCLES - 1)) begin
          w_state_nxt = S_FATAL;
        end else begin
          w_to_nxt = r_to + TW'(1);
        end
`endif
      end
      S_WORK_SPC: w_state_nxt = S_WORK_SGPR;
      S_WORK_SGPR: begin
        if (r_addr == '1) begin
          w_state_nxt = S_DONE;
          w_clean_nxt = '0;
          if (r_recov != 16'hFFFF) w_recov_nxt = r_recov + 16'd1;
        end else begin
          w_addr_nxt = r_addr + ADDR_WIDTH'(1);
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_FATAL;
    endcase

    // Outputs are decoded from the next state so they are registered alongside it.
    w_reset_n = '1;
    w_halt    = '0;
    w_resume  = '0;
    w_shift   = 1'b0;
    w_we_spc  = 1'b0;
    w_we_sgpr = 1'b0;
    w_busy    = 1'b1;
    w_fatal   = 1'b0;
    case (w_state_nxt)
      S_IDLE:      w_busy    = 1'b0;
      S_RESET:     w_reset_n = ~w_mask_nxt;
      S_HALT: begin
        w_halt  = w_mask_nxt;
        w_shift = 1'b1;
      end
      S_HALT_WAIT: w_shift   = 1'b1;
      S_WORK_SPC:  w_we_spc  = 1'b1;
      S_WORK_SGPR: w_we_sgpr = 1'b1;
      S_DONE:      w_resume  = w_mask_nxt;
      default: begin
        w_reset_n = '0;
        w_fatal   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_mask    <= '0;
      r_retries <= '0;
      r_clean   <= '0;
      r_addr    <= '0;
      r_recov   <= '0;
      r_reset_n <= '1;
      r_halt    <= '0;
      r_resume  <= '0;
      r_shift   <= 1'b0;
      r_we_spc  <= 1'b0;
      r_we_sgpr <= 1'b0;
      r_busy    <= 1'b0;
      r_fatal   <= 1'b0;
`ifdef FT_HALT_TIMEOUT_EN
      r_to      <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_mask    <= w_mask_nxt;
      r_retries <= w_retries_nxt;
      r_clean   <= w_clean_nxt;
      r_addr    <= w_addr_nxt;
      r_recov   <= w_recov_nxt;
      r_reset_n <= w_reset_n;
      r_halt    <= w_halt;
      r_resume  <= w_resume;
      r_shift   <= w_shift;
      r_we_spc  <= w_we_spc;
      r_we_sgpr <= w_we_sgpr;
      r_busy    <= w_busy;
      r_fatal   <= w_fatal;
`ifdef FT_HALT_TIMEOUT_EN
      r_to      <= w_to_nxt;
`endif
    end
  end

  assign reset_no      = r_reset_n;
  assign halt_o        = r_halt;
  assign resume_o      = r_resume;
  assign shift_o       = r_shift;
  assign we_spc_o      = r_we_spc;
  assign we_sgpr_o     = r_we_sgpr;
  assign replay_addr_o = r_addr;
  assign busy_o        = r_busy;
  assign fatal_o       = r_fatal;
  assign recov_count_o = r_recov;

endmodule

// File: tb/tb_ft_recovery_ctrl.sv
// Self-checking bench for ft_recovery_ctrl: directed scenarios plus random traffic, every cycle
// compared against a phase-level reference model of the recovery sequence.
module tb_ft_recovery_ctrl;

  localparam int AW = 5, NC = 2, MR = 3, CC = 256, TO = 64;
  localparam int NUM_REG = 2 ** AW;
  localparam int M_IDLE = 0, M_REC = 1, M_FATAL = 2;
  localparam int P_RESET = 1, P_HALT = 2, P_WAIT = 3, P_SPC = 4, P_SGPR = 5, P_DONE = 6;

  logic          clk = 1'b0;
  logic          rst_i, error_i;
  logic [NC-1:0] faulty_i, halted_i;
  logic [NC-1:0] reset_no, halt_o, resume_o;
  logic          shift_o, we_spc_o, we_sgpr_o, busy_o, fatal_o;
  logic [AW-1:0] replay_addr_o;
  logic [15:0]   recov_count_o;

  always #5 clk = ~clk;

  ft_recovery_ctrl #(
    .ADDR_WIDTH(AW), .NUM_CORES(NC), .MAX_RETRIES(MR), .CLEAN_CYCLES(CC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .error_i(error_i), .faulty_i(faulty_i), .halted_i(halted_i),
    .reset_no(reset_no), .halt_o(halt_o), .resume_o(resume_o), .shift_o(shift_o),
    .we_spc_o(we_spc_o), .we_sgpr_o(we_sgpr_o), .replay_addr_o(replay_addr_o),
    .busy_o(busy_o), .fatal_o(fatal_o), .recov_count_o(recov_count_o)
  );

  int n_checks = 0, n_pass = 0, cyc = 0;

  // Reference model: mode, phase within a recovery, and the budget/clean/recovery tallies.
  int            m_mode = M_IDLE, m_ph = 0, m_addr = 0, m_retries = 0, m_clean = 0;
  int            m_recov = 0, m_wait = 0;
  logic [NC-1:0] m_mask = '0;
  int            since = 0, ack_delay = 3;
  bit            no_ack = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", tag, cyc, act, exp);
  endtask

  task automatic model_step(input logic err, input logic [NC-1:0] flt, input logic [NC-1:0] h,
                            input logic rst);
    if (rst) begin
      m_mode = M_IDLE; m_ph = 0; m_addr = 0; m_retries = 0; m_clean = 0;
      m_recov = 0; m_wait = 0; m_mask = '0;
      return;
    end
    case (m_mode)
      M_IDLE: begin
        if (err) begin
          m_clean = 0;
          if (m_retries < MR) begin
            m_mask = (flt == '0) ? '1 : flt;
            m_retries++;
            m_mode = M_REC;
            m_ph   = P_RESET;
          end else begin
            m_mode = M_FATAL;
          end
        end else begin
          m_clean++;
          if (m_clean == CC) begin
            m_clean   = 0;
            m_retries = 0;
          end
        end
      end
      M_REC: begin
        case (m_ph)
          P_RESET: m_ph = P_HALT;
          P_HALT: begin
            m_ph   = P_WAIT;
            m_wait = 0;
          end
          P_WAIT: begin
            if ((h & m_mask) == m_mask) m_ph = P_SPC;
            else begin
`ifdef FT_HALT_TIMEOUT_EN
              m_wait++;
              if (m_wait == TO) m_mode = M_FATAL;
`endif
            end
          end
          P_SPC: begin
            m_ph   = P_SGPR;
            m_addr = 0;
          end
          P_SGPR: begin
            if (m_addr == NUM_REG - 1) begin
              m_ph    = P_DONE;
              m_addr  = 0;
              m_clean = 0;
              if (m_recov < 65535) m_recov++;
            end else begin
              m_addr++;
            end
          end
          default: m_mode = M_IDLE;
        endcase
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    logic [NC-1:0] e_rn, e_h, e_r;
    logic          e_sh, e_spc, e_sg;
    int            e_addr;
    e_rn = '1; e_h = '0; e_r = '0; e_sh = 1'b0; e_spc = 1'b0; e_sg = 1'b0; e_addr = 0;
    if (m_mode == M_FATAL) e_rn = '0;
    else if (m_mode == M_REC) begin
      case (m_ph)
        P_RESET: e_rn = ~m_mask;
        P_HALT:  begin e_h = m_mask; e_sh = 1'b1; end
        P_WAIT:  e_sh = 1'b1;
        P_SPC:   e_spc = 1'b1;
        P_SGPR:  begin e_sg = 1'b1; e_addr = m_addr; end
        default: e_r = m_mask;
      endcase
    end
    check("reset_no", 32'(reset_no), 32'(e_rn));
    check("halt_o", 32'(halt_o), 32'(e_h));
    check("resume_o", 32'(resume_o), 32'(e_r));
    check("shift_o", 32'(shift_o), 32'(e_sh));
    check("we_spc_o", 32'(we_spc_o), 32'(e_spc));
    check("we_sgpr_o", 32'(we_sgpr_o), 32'(e_sg));
    check("replay_addr_o", 32'(replay_addr_o), 32'(e_addr));
    check("busy_o", 32'(busy_o), 32'(m_mode != M_IDLE));
    check("fatal_o", 32'(fatal_o), 32'(m_mode == M_FATAL));
    check("recov_count_o", 32'(recov_count_o), 32'(m_recov));
  endtask

  // One clock: drive inputs (cores ack ack_delay cycles after their halt pulse), advance the model,
  // then compare on the falling edge.
  task automatic tick(input logic err, input logic [NC-1:0] flt, input logic rst);
    logic [NC-1:0] h;
    if (m_mode == M_REC && m_ph == P_HALT) since = 0;
    else since++;
    h = NC'($urandom) & ~m_mask;
    if (m_mode == M_REC && (m_ph == P_HALT || m_ph == P_WAIT) && !no_ack && since >= ack_delay)
      h = h | m_mask;
    rst_i = rst; error_i = err; faulty_i = flt; halted_i = h;
    model_step(err, flt, h, rst);
    @(negedge clk);
    cyc++;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0);
  endtask

  // Error pulse followed by the full recovery; optionally re-pulses error mid-replay.
  task automatic run_recovery(input bit poke, input logic [NC-1:0] flt, output int n_sgpr,
                              output int c0, output int lat, output logic [NC-1:0] first_rn);
    int off;
    n_sgpr = 0; c0 = 0; lat = 0;
    tick(1'b1, flt, 1'b0);
    off = 1;
    first_rn = reset_no;
    if (!reset_no[0] || halt_o[0] || resume_o[0]) c0++;
    for (int i = 0; i < 500 && m_mode == M_REC; i++) begin
      tick(poke && m_ph == P_SGPR && m_addr == 5, '0, 1'b0);
      off++;
      if (we_sgpr_o) n_sgpr++;
      if (!reset_no[0] || halt_o[0] || resume_o[0]) c0++;
      if (resume_o != '0 && lat == 0) lat = off;
    end
    check("recovery_returns_idle", 32'(busy_o), 32'(m_mode != M_IDLE));
  endtask

  initial begin
    int            ns, c0, lat, off, fcnt;
    logic [NC-1:0] frn;
    rst_i = 1'b1; error_i = 1'b0; faulty_i = '0; halted_i = '0;
    tick(1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_reset_no", 32'(reset_no), 32'h3);
    check("rst_recov", 32'(recov_count_o), 32'd0);

    // Single fault on core 1, acknowledge 3 cycles after the halt pulse.
    idle(3);
    ack_delay = 3;
    run_recovery(1'b0, 2'b10, ns, c0, lat, frn);
    check("single_first_reset_no", 32'(frn), 32'h1);
    check("single_sgpr_cycles", 32'(ns), 32'(NUM_REG));
    check("single_core0_quiet", 32'(c0), 32'd0);
    check("single_latency", 32'(lat), 32'(1 + 1 + 3 + 1 + NUM_REG + 1));
    check("single_recov", 32'(recov_count_o), 32'd1);

    // Retry exhaustion: three recoveries then the fourth error is fatal.
    tick(1'b0, '0, 1'b1);
    for (int k = 0; k < MR; k++) begin
      ack_delay = 1 + int'($urandom % 4);
      run_recovery(1'b0, NC'($urandom), ns, c0, lat, frn);
      idle(12);
    end
    tick(1'b1, 2'b01, 1'b0);
    idle(3);
    tick(1'b1, 2'b11, 1'b0);
    idle(2);
    check("exhaust_fatal", 32'(fatal_o), 32'd1);
    check("exhaust_reset_no", 32'(reset_no), 32'd0);
    check("exhaust_recov", 32'(recov_count_o), 32'(MR));

    // Budget refill after a full clean window.
    tick(1'b0, '0, 1'b1);
    for (int k = 0; k < 2; k++) run_recovery(1'b0, NC'($urandom), ns, c0, lat, frn);
    idle(CC);
    for (int k = 0; k < 3; k++) run_recovery(1'b0, NC'($urandom), ns, c0, lat, frn);
    idle(3);
    check("refill_no_fatal", 32'(fatal_o), 32'd0);
    check("refill_recov", 32'(recov_count_o), 32'd5);

    // Error in the very cycle the window would complete wins over the refill.
    tick(1'b0, '0, 1'b1);
    for (int k = 0; k < MR; k++) run_recovery(1'b0, 2'b01, ns, c0, lat, frn);
    idle(CC - 1);
    tick(1'b1, 2'b01, 1'b0);
    idle(2);
    check("refill_race_fatal", 32'(fatal_o), 32'd1);

    // Reset in the middle of the GPR replay.
    tick(1'b0, '0, 1'b1);
    tick(1'b1, 2'b01, 1'b0);
    for (int i = 0; i < 200 && !(m_mode == M_REC && m_ph == P_SGPR && m_addr == 17); i++)
      tick(1'b0, '0, 1'b0);
    check("mid_addr17", 32'(replay_addr_o), 32'd17);
    tick(1'b0, '0, 1'b1);
    check("mid_rst_sgpr", 32'(we_sgpr_o), 32'd0);
    check("mid_rst_addr", 32'(replay_addr_o), 32'd0);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_recov", 32'(recov_count_o), 32'd0);
    for (int k = 0; k < MR; k++) run_recovery(1'b0, 2'b10, ns, c0, lat, frn);
    check("mid_rst_budget", 32'(fatal_o), 32'd0);

    // Zero faulty mask selects all cores; an error inside the replay is ignored.
    tick(1'b0, '0, 1'b1);
    idle(2);
    run_recovery(1'b1, 2'b00, ns, c0, lat, frn);
    check("zero_mask_reset_no", 32'(frn), 32'd0);
    idle(5);
    check("zero_mask_recov", 32'(recov_count_o), 32'd1);
    check("zero_mask_idle", 32'(busy_o), 32'd0);

    // Halt acknowledge never arrives.
    tick(1'b0, '0, 1'b1);
    no_ack = 1'b1;
    tick(1'b1, 2'b01, 1'b0);
`ifdef FT_HALT_TIMEOUT_EN
    off = 1;
    for (int i = 0; i < 200 && !fatal_o; i++) begin
      tick(1'b0, '0, 1'b0);
      off++;
    end
    check("watchdog_fatal_cycle", 32'(off), 32'(2 + TO + 1));
    check("watchdog_reset_no", 32'(reset_no), 32'd0);
`else
    idle(1000);
    check("no_watchdog_fatal", 32'(fatal_o), 32'd0);
    check("no_watchdog_waiting", 32'(shift_o), 32'd1);
    check("no_watchdog_busy", 32'(busy_o), 32'd1);
`endif
    no_ack = 1'b0;

    // Random traffic: sparse and held errors, random masks and acknowledge delays, rare resets.
    tick(1'b0, '0, 1'b1);
    fcnt = 0;
    for (int i = 0; i < 4000; i++) begin
      if (m_mode == M_REC && m_ph == P_HALT) ack_delay = 1 + int'($urandom % 6);
      fcnt = (m_mode == M_FATAL) ? fcnt + 1 : 0;
      if (fcnt > 4 || ($urandom % 1500) == 0) tick(1'b0, NC'($urandom), 1'b1);
      else tick(($urandom % 40) < 2, NC'($urandom), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ft_recovery_ctrl.md
Name: ft_recovery_ctrl

Overview:
Parametrised fault-tolerance recovery sequencer for the N-core lockstep cluster. On a voter mismatch it resets, halts and waits for the faulty core(s). It then replays the saved PC and all GPRs from the shadow register file and resumes the cores. Unlike the previous single-core controller it adds:
- per-core masks
- a bounded retry budget with a clean-window refill
- a fatal state
- a recovery counter
- an optional halt-acknowledge watchdog

Parameters:
ADDR_WIDTH, 5, GPR address width; NUM_REG = 2**ADDR_WIDTH registers replayed
NUM_CORES, 2, number of cores under supervision (>=1)
MAX_RETRIES, 3, recoveries allowed inside one un-refilled window (>=1)
CLEAN_CYCLES, 256, error-free idle cycles that reset the retry budget
TIMEOUT_CYCLES, 64, halt-acknowledge watchdog limit (used only with the optional feature)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
error_i  in  1  voter mismatch, level
faulty_i  in  NUM_CORES  faulty-core mask from voter, valid while error_i=1
halted_i  in  NUM_CORES  per-core debug halted status
reset_no  out  NUM_CORES  per-core reset, active-low (1 = run)
halt_o  out  NUM_CORES  per-core halt request, 1-cycle pulse
resume_o  out  NUM_CORES  per-core resume request, 1-cycle pulse
shift_o  out  1  shadow-register shift enable
we_spc_o  out  1  write saved PC into core
we_sgpr_o  out  1  write saved GPR into core
replay_addr_o  out  ADDR_WIDTH  GPR replay address
busy_o  out  1  high in every state except IDLE
fatal_o  out  1  sticky unrecoverable-fault flag
recov_count_o  out  16  completed recoveries, saturates at 16'hFFFF

Behaviour:
- Reset (rst_i=1 at a clock edge) takes effect on that edge, from any state, including mid-replay:
  - state=IDLE
  - reset_no all 1
  - halt_o, resume_o, shift_o, we_spc_o, we_sgpr_o all 0
  - replay_addr_o=0, busy_o=0, fatal_o=0, recov_count_o=0
  - retry counter=0, clean counter=0, captured mask=0
- All outputs are registered.
- error_i and faulty_i are sampled only in IDLE; in all other states they are ignored and not queued.
- States and transitions:
  - IDLE:
    - If error_i=1 and retries<MAX_RETRIES: latch mask = faulty_i; if faulty_i==0, mask = all ones. Go to RESET.
    - If error_i=1 and retries==MAX_RETRIES: go to FATAL.
    - Otherwise increment the clean counter; when it reaches CLEAN_CYCLES, set retries=0 and clean counter=0.
    - Any error_i=1 in IDLE clears the clean counter.
  - RESET (1 cycle): reset_no[k]=0 for masked k; retries+=1. Go to HALT.
  - HALT (1 cycle): reset_no back to all 1; halt_o=mask; shift_o=1. Go to HALT_WAIT.
  - HALT_WAIT: halt_o=0; shift_o stays 1. When (halted_i & mask)==mask, go to WORK_SPC. With no acknowledge it waits indefinitely (see optional feature).
  - WORK_SPC (1 cycle): shift_o=0; we_spc_o=1; replay_addr_o=0. Go to WORK_SGPR.
  - WORK_SGPR (exactly NUM_REG cycles):
    - we_spc_o=0, we_sgpr_o=1.
    - replay_addr_o = 0,1,…,NUM_REG-1, one address per cycle.
    - After the cycle with address NUM_REG-1, go to DONE. There is no wrap past NUM_REG-1.
  - DONE (1 cycle): we_sgpr_o=0; resume_o=mask; recov_count_o+=1 (saturating); clean counter=0. Go to IDLE.
  - FATAL: fatal_o=1; reset_no all 0 (all cores held in reset); all other strobes 0; busy_o=1. Only rst_i exits.
- Latency: error_i sampled in IDLE → first reset_no low 1 cycle later. Total error-to-resume latency = 1 (RESET) + 1 (HALT) + W (HALT_WAIT cycles, W≥1) + 1 (WORK_SPC) + NUM_REG (WORK_SGPR) + 1 (DONE), counted from the cycle after sampling.
- Simultaneous events:
  - error_i held high through DONE is seen again in IDLE on the next cycle, starting a new recovery that consumes a retry.
  - A clean-window refill and an error in the same IDLE cycle: the error wins; the budget is not refilled.
- Non-masked cores see no reset, halt or resume activity.

Optional Feature:
FT_HALT_TIMEOUT_EN
- Defined: a counter starts at 0 on entry to HALT_WAIT. If TIMEOUT_CYCLES cycles elapse with (halted_i & mask)!=mask, the block goes to FATAL. An acknowledge arriving in the same cycle the limit is reached wins and the block goes to WORK_SPC.
- Undefined: no counter is instantiated and HALT_WAIT waits forever. TIMEOUT_CYCLES is unused.

Test Plan:
- Single fault, NUM_CORES=2: faulty_i=2'b10, error_i 1-cycle pulse, halted_i[1] rises 3 cycles after halt_o → reset_no=2'b01 for 1 cycle; halt_o=2'b10 pulse; we_spc_o 1 cycle; we_sgpr_o for 32 cycles with addresses 0..31; resume_o=2'b10; recov_count_o=1; core 0 strobes never asserted.
- Retry exhaustion, MAX_RETRIES=3: four errors spaced 50 cycles apart (window of 256 never completes) → three full recoveries, fourth error gives FATAL; fatal_o=1, reset_no=2'b00, recov_count_o=3.
- Budget refill: two recoveries, then 256 idle error-free cycles, then three more errors → no FATAL; recov_count_o=5.
- Mid-operation reset: assert rst_i while replay_addr_o=17 in WORK_SGPR → next cycle state IDLE, we_sgpr_o=0, replay_addr_o=0, counters 0.
- Zero mask and error during recovery: faulty_i=0 with error_i=1 → mask=2'b11. A second error_i pulse inside WORK_SGPR causes no extra recovery (recov_count_o=1).
- With FT_HALT_TIMEOUT_EN, TIMEOUT_CYCLES=64: halted_i held 0 → FATAL entered 64 cycles after HALT_WAIT entry. Without the macro → still in HALT_WAIT at 1000 cycles, fatal_o=0.
